// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: samples a probe bus into a circular buffer with a
// programmable pre-trigger window, then replays it oldest-first through a registered read port.
module la_capture_core #(
  parameter int DATA_W = 56,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int TRIG_W = 2
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                abort,
  input  logic                sample_en,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [TRIG_W-1:0]   trig_i,
  input  logic [2*TRIG_W-1:0] trig_mode,
  input  logic                trig_comb,
  input  logic [ADDR_W-1:0]   pre_cnt,
  output logic [2:0]          state_o,
  output logic                trig_seen,
  output logic                done,
  output logic [ADDR_W-1:0]   trig_addr,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRETRIG = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                state_reg;
  logic [ADDR_W-1:0]     wr_ptr_reg;
  logic [ADDR_W-1:0]     cnt_reg;
  logic [ADDR_W-1:0]     pre_reg;
  logic [2*TRIG_W-1:0]   mode_reg;
  logic                  comb_reg;
  logic [TRIG_W-1:0]     trig_q_reg;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  capturing;
  logic                  wr_en;
  logic [TRIG_W-1:0]     bit_hit;
  logic [TRIG_W-1:0]     bit_use;
  logic                  trig_fire;
  logic [ADDR_W-1:0]     post_load;
  logic [ADDR_W-1:0]     rd_phys;

  assign capturing = (state_reg == S_PRETRIG) || (state_reg == S_ARMED) || (state_reg == S_POST);
  assign wr_en     = sample_en && capturing && !abort;

  generate
    for (genvar gi = 0; gi < TRIG_W; gi++) begin : g_trig
      logic [1:0] m;
      assign m            = mode_reg[2*gi +: 2];
      assign bit_use[gi]  = (m != 2'b00);
      assign bit_hit[gi]  = ((m == 2'b01) &&  trig_i[gi]) ||
                            ((m == 2'b10) &&  trig_i[gi] && !trig_q_reg[gi]) ||
                            ((m == 2'b11) && !trig_i[gi] &&  trig_q_reg[gi]);
    end
  endgenerate

  // AND with every bit ignored fires at once; OR with every bit ignored never fires.
  assign trig_fire = comb_reg ? (|bit_hit) : (&(bit_hit | ~bit_use));
  assign post_load = {ADDR_W{1'b1}} - pre_reg;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
      pre_reg    <= '0;
      mode_reg   <= '0;
      comb_reg   <= 1'b0;
      trig_q_reg <= '0;
      trig_seen  <= 1'b0;
      trig_addr  <= '0;
    end else begin
      if (sample_en) trig_q_reg <= trig_i;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;

      if (abort) begin
        state_reg <= S_IDLE;
        trig_seen <= 1'b0;
      end else begin
        unique case (state_reg)
          S_IDLE, S_DONE: begin
            if (arm) begin
              pre_reg    <= pre_cnt;
              mode_reg   <= trig_mode;
              comb_reg   <= trig_comb;
              wr_ptr_reg <= '0;
              cnt_reg    <= '0;
              trig_seen  <= 1'b0;
              state_reg  <= (pre_cnt != '0) ? S_PRETRIG : S_ARMED;
            end
          end
          S_PRETRIG: begin
            if (sample_en) begin
              if (cnt_reg == pre_reg - 1'b1) state_reg <= S_ARMED;
              else cnt_reg <= cnt_reg + 1'b1;
            end
          end
          S_ARMED: begin
            if (sample_en && trig_fire) begin
              trig_addr <= wr_ptr_reg;
              trig_seen <= 1'b1;
              cnt_reg   <= post_load;
              state_reg <= (post_load == '0) ? S_DONE : S_POST;
            end
          end
          S_POST: begin
            if (sample_en) begin
              cnt_reg <= cnt_reg - 1'b1;
              if (cnt_reg == ADDR_W'(1)) state_reg <= S_DONE;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr_reg] <= data_i;
  end

  // Logical index 0 maps to the oldest sample, pre_reg entries before the trigger.
  assign rd_phys = trig_addr - pre_reg + rd_addr;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_phys];
  end

  assign state_o = state_reg;
  assign done    = (state_reg == S_DONE);

endmodule

// File: doc/la_capture_core.md
Name: la_capture_core

Overview:
Parametrised on-chip logic-analyser capture engine for debugging the video pipeline and its loaders. Probe buses include the H/V counters, sync/DE and PROM loader handshakes. Samples a DATA_W-bit probe bus into a DEPTH-entry circular buffer with a programmable pre-trigger window. The trigger is multi-bit, with per-bit level/edge modes and AND/OR combining. Captured data is read back in chronological order through a synchronous read port, for a JTAG/UART bridge or an on-screen overlay.

Parameters:
DATA_W, 56, probe bus width
DEPTH, 1024, buffer entries; power of two, >= 4
ADDR_W, log2(DEPTH), buffer index width (derived, do not override)
TRIG_W, 2, number of trigger inputs

Ports:
sys_clk  in  1  capture and readout clock
rst  in  1  asynchronous, active-high reset
arm  in  1  single-cycle pulse; starts a capture from IDLE or DONE
abort  in  1  single-cycle pulse; returns to IDLE from any state
sample_en  in  1  sample qualifier; buffer writes and trigger evaluation only when 1
data_i  in  DATA_W  probe bus
trig_i  in  TRIG_W  trigger inputs
trig_mode  in  2*TRIG_W  per trigger bit k, field [2k+1:2k]: 00 ignore, 01 high level, 10 rising edge, 11 falling edge
trig_comb  in  1  0 = AND of non-ignored bits, 1 = OR
pre_cnt  in  ADDR_W  samples kept before the trigger sample; must be <= DEPTH-1
state_o  out  3  0 IDLE, 1 PRETRIG, 2 ARMED, 3 POST, 4 DONE
trig_seen  out  1  trigger has fired in the current capture
done  out  1  buffer complete and readable
trig_addr  out  ADDR_W  physical buffer index of the trigger sample
rd_addr  in  ADDR_W  logical index; 0 = oldest sample, pre_cnt = trigger sample
rd_data  out  DATA_W  sample at rd_addr, one-cycle latency

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state IDLE; trig_seen, done, trig_addr, rd_data = 0.
  - wr_ptr, counters and trigger history = 0.
  - Buffer contents are not cleared.
- pre_cnt and trig_mode/trig_comb are latched on the accepted arm cycle; later changes are ignored until the next arm.
- arm accepted only in IDLE or DONE. On acceptance:
  - wr_ptr = 0; fill counter = 0; trig_seen and done clear.
  - Next state is PRETRIG if latched pre_cnt > 0, else ARMED.
- arm in PRETRIG/ARMED/POST is ignored.
- abort has priority over arm in the same cycle: next state IDLE, done = 0, trig_seen = 0.
- Every sample_en cycle in PRETRIG/ARMED/POST writes data_i to mem[wr_ptr]; wr_ptr increments modulo DEPTH, wrapping DEPTH-1 -> 0.
- PRETRIG:
  - Counts written samples; after pre_cnt samples, go to ARMED.
  - Trigger is not evaluated in PRETRIG.
- Trigger history: trig_q <= trig_i on every sample_en cycle, in all states. Edges are relative to the previous qualified sample.
- Trigger evaluation (ARMED, sample_en = 1):
  - Per-bit match: level = trig_i[k]; rising = trig_i[k] & ~trig_q[k]; falling = ~trig_i[k] & trig_q[k].
  - AND mode: all non-ignored bits match; all bits ignored = immediate trigger.
  - OR mode: any non-ignored bit matches; all bits ignored = never triggers.
- On trigger:
  - The current sample is written at wr_ptr and trig_addr <= wr_ptr; trig_seen = 1.
  - Post counter loads DEPTH-1-pre_cnt; go to POST, or directly to DONE when the load value is 0.
- ARMED overwrites the oldest entries indefinitely until a trigger fires.
- POST: each written sample decrements the post counter; the write that reaches 0 moves state to DONE next cycle. No writes occur in DONE/IDLE.
- A capture always holds exactly DEPTH samples: pre_cnt + 1 + (DEPTH-1-pre_cnt).
- Readout:
  - start = (trig_addr - pre_cnt) mod DEPTH; physical read index = (start + rd_addr) mod DEPTH, ADDR_W wrap arithmetic.
  - rd_data is registered and valid one cycle after rd_addr.
  - Reads are defined only in DONE; in other states rd_data returns mem contents without guarantees.
- done is high exactly while state is DONE.
- Buffer is inferred as simple dual-port block RAM: one write port, one registered read port.

Test Plan:
- DEPTH=16, pre_cnt=4, mode bit0 rising, AND; data_i = sample counter 0,1,2...; trig_i[0] rises at sample 10 -> trig_addr=10, done after sample 21; rd_addr 0..15 return 6..21, rd_addr 4 returns 10.
- DEPTH=16, pre_cnt=0, bit0 level-high already high at arm -> triggers on first sample (data 0); rd_addr 0..15 return 0..15; PRETRIG never entered.
- pre_cnt=15, trigger after wrap (sample 40) -> POST skipped, DONE next cycle; rd_addr 0 returns 25, rd_addr 15 returns 40.
- sample_en toggling 1/0 every cycle, pre_cnt=4 -> identical buffer contents to the continuous case; edges are detected across gated cycles only.
- OR mode with bit0 falling and bit1 level-high; bit1 asserts first -> trigger on bit1; all bits ignore in OR -> stays ARMED for 100 samples, done=0.
- abort in POST -> IDLE, done=0, trig_seen=0. arm and abort together -> IDLE. rst asserted in ARMED -> all outputs 0 immediately. Re-arm from DONE -> new capture completes correctly.
